// File: rtl/smem_collector_pkg.sv
// Shared types for the SMEM collector: the WorkingMem record, the collector FSM states
// and the containment test used by the filter.
package smem_collector_pkg;

    localparam int POS_W       = 32;
    localparam int KLS_W       = 32;
    localparam int SMEM_BUF_AW = 6;

    typedef struct packed {
        logic [POS_W-1:0] j;
        logic [POS_W-1:0] i;
        logic [KLS_W-1:0] s;
        logic [KLS_W-1:0] l;
        logic [KLS_W-1:0] k;
    } working_mem_t;

    localparam int WM_W = $bits(working_mem_t);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_FETCH   = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } smem_coll_state_e;

    // A record lies inside the previous one when its [i,j] span is covered by it.
    function automatic logic is_contained(input working_mem_t rec, input working_mem_t prev);
        return (rec.i >= prev.i) && (rec.j <= prev.j);
    endfunction

endpackage

// File: rtl/smem_collector_if.sv
// AXI4-Stream bundle carrying WorkingMem records between the seeker, collector and chain logic.
interface smem_collector_if
    import smem_collector_pkg::*;
#(
    parameter int DW = WM_W
);
    logic [DW-1:0]   tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic [DW/8-1:0] tstrb;
    logic [DW/8-1:0] tkeep;

    modport master (output tdata, tvalid, tlast, tstrb, tkeep, input tready);
    modport slave  (input tdata, tvalid, tlast, tstrb, tkeep, output tready);
endinterface

// File: rtl/smem_collector_ram.sv
// Simple dual-port synchronous RAM with a registered, enable-gated read port.
module smem_collector_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Write port and read register; the read register holds while i_re is low.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/smem_collector.sv
// Filters SMEM records from the seeker, buffers them per read and drains them as one
// AXI4-Stream packet when the read has been fully seeked.
module smem_collector
    import smem_collector_pkg::*;
#(
    parameter int BUF_AW = SMEM_BUF_AW
) (
    input  logic               clk,
    input  logic               rst,
    smem_collector_if.slave    s_axis_emout,
    smem_collector_if.master   m_axis_smem,
    input  logic [KLS_W-1:0]   i_max_occ_in,
    input  logic               i_max_occ_valid,
    input  logic               i_read_done,
    output logic [BUF_AW:0]    o_rec_cnt,
    output logic               o_overflow,
    output logic               o_busy,
    output logic               o_done
);
    localparam int              CNT_W = BUF_AW + 1;
    localparam int              KW    = WM_W / 8;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << BUF_AW;

    smem_coll_state_e  r_state;
    logic [CNT_W-1:0]  r_rec_cnt;
    logic [BUF_AW-1:0] r_rd_ptr;
    logic [KLS_W-1:0]  r_max_occ;
    working_mem_t      r_last;
    logic              r_last_vld;
    logic              r_overflow;
    logic              r_busy;
    logic              r_done;
    logic              r_m_tvalid;
    logic              r_m_tlast;
    logic              r_s_tready;

    working_mem_t      w_rec;
    logic              w_accept;
    logic              w_pass;
    logic              w_full;
    logic              w_store;
    logic              w_lost;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_re;
    logic              w_beat;
    logic [WM_W-1:0]   w_rdata;

    assign w_rec     = working_mem_t'(s_axis_emout.tdata);
    assign w_accept  = s_axis_emout.tvalid & r_s_tready;
    assign w_pass    = (w_rec.s != {KLS_W{1'b0}}) && (w_rec.s <= r_max_occ)
                       && !(r_last_vld && is_contained(w_rec, r_last));
    assign w_full    = (r_rec_cnt == DEPTH);
    assign w_store   = w_accept & w_pass & ~w_full;
    assign w_lost    = w_accept & w_pass & w_full;
    assign w_cnt_nxt = r_rec_cnt + CNT_W'(w_store);
    assign w_re      = (r_state == S_FETCH);
    assign w_beat    = r_m_tvalid & m_axis_smem.tready;

    smem_collector_ram #(
        .DW (WM_W),
        .AW (BUF_AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (r_rec_cnt[BUF_AW-1:0]),
        .i_wdata (w_rec),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Occurrence threshold, updatable in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_occ <= {KLS_W{1'b1}};
        end else if (i_max_occ_valid) begin
            r_max_occ <= i_max_occ_in;
        end
    end

    // Collect / fetch / drain / done sequencer with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_COLLECT;
            r_rec_cnt  <= {CNT_W{1'b0}};
            r_rd_ptr   <= {BUF_AW{1'b0}};
            r_last     <= {WM_W{1'b0}};
            r_last_vld <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_s_tready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_store) begin
                        r_rec_cnt  <= w_cnt_nxt;
                        r_last     <= w_rec;
                        r_last_vld <= 1'b1;
                    end
                    if (w_lost) begin
                        r_overflow <= 1'b1;
                    end
                    // The beat accepted alongside read_done is already in w_cnt_nxt.
                    if (i_read_done) begin
                        r_s_tready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_cnt_nxt != {CNT_W{1'b0}}) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    r_state    <= S_DRAIN;
                    r_m_tvalid <= 1'b1;
                    r_m_tlast  <= ({1'b0, r_rd_ptr} == (r_rec_cnt - CNT_W'(1)));
                end
                S_DRAIN: begin
                    if (w_beat) begin
                        r_rd_ptr   <= r_rd_ptr + BUF_AW'(1);
                        r_m_tvalid <= 1'b0;
                        r_m_tlast  <= 1'b0;
                        if (r_m_tlast) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state    <= S_COLLECT;
                    r_rec_cnt  <= {CNT_W{1'b0}};
                    r_rd_ptr   <= {BUF_AW{1'b0}};
                    r_overflow <= 1'b0;
                    r_last_vld <= 1'b0;
                    r_busy     <= 1'b0;
                    r_s_tready <= 1'b1;
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    assign s_axis_emout.tready = r_s_tready;
    assign m_axis_smem.tvalid  = r_m_tvalid;
    assign m_axis_smem.tdata   = w_rdata;
    assign m_axis_smem.tlast   = r_m_tlast;
    assign m_axis_smem.tstrb   = {KW{1'b1}};
    assign m_axis_smem.tkeep   = {KW{1'b1}};
    assign o_rec_cnt           = r_rec_cnt;
    assign o_overflow          = r_overflow;
    assign o_busy              = r_busy;
    assign o_done              = r_done;
endmodule

// File: tb/tb_smem_collector.sv
// Directed self-checking bench for smem_collector (buffer of 4 records).
module tb_smem_collector;
    import smem_collector_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    smem_collector_if s_if ();
    smem_collector_if m_if ();

    logic [KLS_W-1:0] max_occ_in;
    logic             max_occ_valid;
    logic             read_done;
    logic [2:0]       rec_cnt;
    logic             overflow, busy, done;

    smem_collector #(.BUF_AW(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_emout    (s_if),
        .m_axis_smem     (m_if),
        .i_max_occ_in    (max_occ_in),
        .i_max_occ_valid (max_occ_valid),
        .i_read_done     (read_done),
        .o_rec_cnt       (rec_cnt),
        .o_overflow      (overflow),
        .o_busy          (busy),
        .o_done          (done)
    );

    int checks = 0;
    int errors = 0;

    working_mem_t got_q[$];
    bit           last_q[$];
    int           unstable;
    bit           saw_done;
    bit           timed_out;

    function automatic working_mem_t mk(input int i, input int j, input int s);
        working_mem_t r;
        r.j = POS_W'(j);
        r.i = POS_W'(i);
        r.s = KLS_W'(s);
        r.l = KLS_W'(i + j);
        r.k = KLS_W'(1000 + i);
        return r;
    endfunction

    task automatic send_beat(input working_mem_t r, input bit with_rd);
        s_if.tdata  = r;
        s_if.tvalid = 1'b1;
        read_done   = with_rd;
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        read_done   = 1'b0;
    endtask

    task automatic pulse_read_done();
        read_done = 1'b1;
        @(posedge clk); #1;
        read_done = 1'b0;
    endtask

    task automatic set_max_occ(input int v);
        max_occ_in    = KLS_W'(v);
        max_occ_valid = 1'b1;
        @(posedge clk); #1;
        max_occ_valid = 1'b0;
    endtask

    // Records output beats until done (or stop_after beats); ends sampling at a negedge.
    task automatic capture(input bit stall, input int stop_after, input int budget);
        working_mem_t held;
        bit           holding;
        got_q.delete();
        last_q.delete();
        unstable  = 0;
        saw_done  = 1'b0;
        timed_out = 1'b1;
        holding   = 1'b0;
        held      = '0;
        for (int c = 0; c < budget; c++) begin
            m_if.tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (m_if.tvalid) begin
                if (holding && (m_if.tdata !== held)) unstable++;
                if (m_if.tready) begin
                    got_q.push_back(working_mem_t'(m_if.tdata));
                    last_q.push_back(m_if.tlast);
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = m_if.tdata;
                end
            end
            if (done) saw_done = 1'b1;
            if (saw_done || (stop_after > 0 && got_q.size() == stop_after)) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (rec_cnt !== 3'd0) begin errors++; $display("FAIL reset_rec_cnt got %0d want 0", rec_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy got %b%b want 00", done, busy); end
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %b want 0", m_if.tvalid); end
        checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready got %b want 1", s_if.tready); end
    endtask

    task automatic test_filter();
        set_max_occ(10);
        send_beat(mk(0, 19, 3), 1'b0);
        send_beat(mk(5, 30, 12), 1'b0);
        checks++; if (rec_cnt !== 3'd1) begin errors++; $display("FAIL filter_rec_cnt got %0d want 1", rec_cnt); end
        pulse_read_done();
        capture(1'b0, 0, 50);
        checks++; if (timed_out || got_q.size() != 1) begin errors++; $display("FAIL filter_beats got %0d want 1 (timeout %b)", got_q.size(), timed_out); end
        else begin
            checks++; if (got_q[0] !== mk(0, 19, 3)) begin errors++; $display("FAIL filter_data got %h want %h", got_q[0], mk(0, 19, 3)); end
            checks++; if (last_q[0] !== 1'b1) begin errors++; $display("FAIL filter_tlast got %b want 1", last_q[0]); end
        end
        @(posedge clk); #1;
        checks++; if (rec_cnt !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL filter_after got cnt=%0d busy=%b done=%b want 0/0/0", rec_cnt, busy, done); end
    endtask

    task automatic test_containment();
        send_beat(mk(2, 40, 1), 1'b0);
        send_beat(mk(3, 35, 2), 1'b0);
        send_beat(mk(1, 35, 2), 1'b0);
        checks++; if (rec_cnt !== 3'd2) begin errors++; $display("FAIL contain_rec_cnt got %0d want 2", rec_cnt); end
        pulse_read_done();
        capture(1'b0, 0, 50);
        checks++; if (timed_out || got_q.size() != 2) begin errors++; $display("FAIL contain_beats got %0d want 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== mk(2, 40, 1) || got_q[1] !== mk(1, 35, 2)) begin errors++; $display("FAIL contain_order got %h / %h", got_q[0], got_q[1]); end
            checks++; if (last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin errors++; $display("FAIL contain_tlast got %b%b want 01", last_q[0], last_q[1]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_occ_boundary();
        set_max_occ(5);
        send_beat(mk(0, 10, 0), 1'b0);
        send_beat(mk(1, 20, 5), 1'b0);
        send_beat(mk(2, 30, 6), 1'b0);
        send_beat(mk(3, 40, 4), 1'b1);
        checks++; if (rec_cnt !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL bound_rec_cnt got %0d busy=%b want 2 busy=1", rec_cnt, busy); end
        capture(1'b0, 0, 50);
        checks++; if (timed_out || got_q.size() != 2) begin errors++; $display("FAIL bound_beats got %0d want 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== mk(1, 20, 5) || got_q[1] !== mk(3, 40, 4)) begin errors++; $display("FAIL bound_data got %h / %h", got_q[0], got_q[1]); end
        end
        @(posedge clk); #1;
        set_max_occ(10);
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 6; k++) send_beat(mk(k, 10 + k, k + 1), 1'b0);
        checks++; if (rec_cnt !== 3'd4) begin errors++; $display("FAIL ovf_rec_cnt got %0d want 4", rec_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        pulse_read_done();
        capture(1'b0, 0, 80);
        checks++; if (timed_out || got_q.size() != 4) begin errors++; $display("FAIL ovf_beats got %0d want 4", got_q.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_q[k] !== mk(k, 10 + k, k + 1) || last_q[k] !== (k == 3)) begin
                    errors++; $display("FAIL ovf_beat%0d got %h last=%b want %h last=%b", k, got_q[k], last_q[k], mk(k, 10 + k, k + 1), k == 3);
                end
            end
        end
        @(posedge clk); #1;
        checks++; if (overflow !== 1'b0 || rec_cnt !== 3'd0) begin errors++; $display("FAIL ovf_clear got ovf=%b cnt=%0d want 0/0", overflow, rec_cnt); end
    endtask

    task automatic test_empty();
        pulse_read_done();
        checks++; if (busy !== 1'b1 || done !== 1'b1 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL empty_pulse got busy=%b done=%b tvalid=%b want 1/1/0", busy, done, m_if.tvalid); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL empty_after got busy=%b done=%b tvalid=%b want 0/0/0", busy, done, m_if.tvalid); end
    endtask

    task automatic test_stall();
        send_beat(mk(10, 50, 2), 1'b0);
        send_beat(mk(11, 60, 3), 1'b0);
        send_beat(mk(12, 70, 4), 1'b0);
        pulse_read_done();
        capture(1'b1, 0, 400);
        m_if.tready = 1'b1;
        checks++; if (timed_out || got_q.size() != 3) begin errors++; $display("FAIL stall_beats got %0d want 3 (timeout %b)", got_q.size(), timed_out); end
        else begin
            checks++; if (got_q[0] !== mk(10, 50, 2) || got_q[1] !== mk(11, 60, 3) || got_q[2] !== mk(12, 70, 4)) begin errors++; $display("FAIL stall_data got %h", got_q[1]); end
            checks++; if (last_q[0] !== 1'b0 || last_q[1] !== 1'b0 || last_q[2] !== 1'b1) begin errors++; $display("FAIL stall_tlast got %b%b%b want 001", last_q[0], last_q[1], last_q[2]); end
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", unstable); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 0; k < 4; k++) send_beat(mk(20 + k, 100 + 10 * k, 1), 1'b0);
        pulse_read_done();
        capture(1'b0, 2, 50);
        checks++; if (timed_out || last_q.size() != 2 || last_q[0] !== 1'b0 || last_q[1] !== 1'b0) begin errors++; $display("FAIL rstmid_first2 got %0d beats (timeout %b)", got_q.size(), timed_out); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (m_if.tvalid !== 1'b0 || rec_cnt !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort got tvalid=%b cnt=%0d busy=%b want 0/0/0", m_if.tvalid, rec_cnt, busy); end
        send_beat(mk(7, 77, 200), 1'b0);
        checks++; if (rec_cnt !== 3'd1) begin errors++; $display("FAIL rstmid_newcnt got %0d want 1", rec_cnt); end
        pulse_read_done();
        capture(1'b0, 0, 50);
        checks++; if (timed_out || got_q.size() != 1 || got_q[0] !== mk(7, 77, 200) || last_q[0] !== 1'b1) begin errors++; $display("FAIL rstmid_newread got %0d beats (timeout %b)", got_q.size(), timed_out); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst           = 1'b1;
        read_done     = 1'b0;
        max_occ_in    = '0;
        max_occ_valid = 1'b0;
        s_if.tdata    = '0;
        s_if.tvalid   = 1'b0;
        s_if.tlast    = 1'b0;
        s_if.tstrb    = '1;
        s_if.tkeep    = '1;
        m_if.tready   = 1'b1;
        test_reset();
        test_filter();
        test_containment();
        test_occ_boundary();
        test_overflow();
        test_empty();
        test_stall();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
